alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, operand and result width in bits (legal range 4..64).
REQ-002 The module SHALL have parameter MUL_EN, default 1; 1 = iterative multiply implemented, 0 = opcode 110 treated as reserved.
REQ-003 The module SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 The module SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1, operation request present.
REQ-006 The module SHALL have port in_ready, output, 1, module can accept a request this cycle.
REQ-007 The module SHALL have ports x and y, input, WIDTH, operands.
REQ-008 The module SHALL have port opcode, input, 3, operation select.
REQ-009 The module SHALL have port out_valid, output, 1, result registers hold an unconsumed result.
REQ-010 The module SHALL have port out_ready, input, 1, consumer takes the result this cycle.
REQ-011 The module SHALL have port f, output, WIDTH, registered result.
REQ-012 The module SHALL have ports overflow, cout and zero, output, 1 each, registered flags.
REQ-013 The module SHALL have port busy, output, 1, multiply in progress.

Function
REQ-014 Opcode map SHALL be 000 add, 001 or, 010 and, 011 sub, 100 slt (signed), 101 sltu (unsigned), 110 mul (low WIDTH bits of the unsigned product), 111 reserved.
REQ-015 A request SHALL be accepted on a rising edge where in_valid && in_ready; x, y and opcode are sampled only then.
REQ-016 in_ready SHALL equal !rst && state==IDLE && (!out_valid || out_ready).
REQ-017 For opcodes other than mul, result and flags SHALL be registered on the accept edge, giving out_valid=1 from the next cycle (latency 1) and sustaining 1 accept per cycle while out_ready=1.
REQ-018 add: f = (x+y) mod 2^WIDTH; cout = carry out of the MSB; overflow = signed overflow (operands same sign, result sign differs).
REQ-019 sub: f = (x + ~y + 1) mod 2^WIDTH; cout = carry out of that sum (1 when x >= y unsigned); overflow = signed overflow of x-y.
REQ-020 slt: f = 1 if x < y signed, else 0, computed as sign(x-y) XOR overflow(x-y); sltu: f = 1 if x < y unsigned; both SHALL drive f[WIDTH-1:1]=0 and cout=overflow=0.
REQ-021 or/and: f = bitwise x|y / x&y; cout=overflow=0.
REQ-022 zero SHALL equal 1 exactly when the registered f is all zeros, for every opcode.
REQ-023 The FSM SHALL have states IDLE and MUL; accepting mul moves IDLE->MUL and asserts busy.
REQ-024 MUL SHALL perform shift-add of one multiplier bit per cycle for WIDTH cycles, then load f, set out_valid, return to IDLE; out_valid rises exactly WIDTH cycles after the accept edge.
REQ-025 mul flags SHALL be: overflow = 1 if the upper WIDTH bits of the full 2*WIDTH product are nonzero; cout=0.
REQ-026 in_ready SHALL be 0 for the whole of MUL; the previous result may be consumed during MUL.
REQ-027 If MUL completes while out_valid=1 and out_ready=0, the FSM SHALL remain in MUL with the product held until the output register frees, then load it on the following edge.
REQ-028 Reserved opcode (and mul when MUL_EN=0): f=0, zero=1, cout=overflow=0, latency 1.
REQ-029 While out_valid=1 and out_ready=0, f and all flags SHALL remain stable.
REQ-030 On an edge with out_ready=1 and no new result, out_valid SHALL clear; simultaneous consume and accept SHALL keep out_valid=1 with the new result.

Reset
REQ-031 While rst=1 on a rising edge: state=IDLE, out_valid=0, busy=0, f=0, overflow=0, cout=0, zero=0, multiply datapath cleared.
REQ-032 in_ready SHALL be 0 in any cycle with rst=1.
REQ-033 Reset during MUL SHALL abort the multiply with no result ever presented.

Verification
REQ-034 add x=1024, y=128, out_ready=1 -> next cycle f=1152, zero=0, cout=0, overflow=0, out_valid=1.
REQ-035 add x=0xFFFFFFFF, y=1 -> f=0, zero=1, cout=1, overflow=0; sub x=0x80000000, y=1 -> f=0x7FFFFFFF, overflow=1, cout=1.
REQ-036 slt x=0xFFFFFFFF, y=1 -> f=1; sltu same operands -> f=0; back-to-back accepts, one per cycle, results in order.
REQ-037 mul x=7, y=6 -> in_ready=0, busy=1 for 32 cycles, f=42, overflow=0 exactly 32 cycles after accept; mul x=0x10000, y=0x10000 -> f=0, overflow=1, zero=1.
REQ-038 Hold out_ready=0 for 5 cycles after an add result -> f/flags stable, in_ready=0, no new accept; rst=1 at cycle 10 of a mul -> next cycle out_valid=0, busy=0, and no stale product appears afterwards.

Source files
------------

// File: rtl/alu_pipe.sv
// Pipelined ALU: single-cycle add/sub/logic/compare ops and an iterative
// shift-add multiplier, with a valid/ready handshake on both sides.
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             overflow,
  output logic             cout,
  output logic             zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_OR   = 3'b001,
    OP_AND  = 3'b010,
    OP_SUB  = 3'b011,
    OP_SLT  = 3'b100,
    OP_SLTU = 3'b101,
    OP_MUL  = 3'b110,
    OP_RSV  = 3'b111
  } op_t;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_out_free;
  logic             w_mul_last;
  logic             w_mul_load;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_ovf_add;
  logic             w_ovf_sub;
  logic [WIDTH-1:0] w_f;
  logic             w_ovf;
  logic             w_cout;

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH-1:0] r_f;
  logic             r_out_valid;
  logic             r_ovf;
  logic             r_cout;
  logic             r_zero;

  assign w_is_mul   = (MUL_EN != 0) && (opcode == OP_MUL);
  assign w_out_free = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;

  // Single-cycle datapath
  assign w_sum     = {1'b0, x} + {1'b0, y};
  assign w_diff    = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
  assign w_ovf_add = (x[WIDTH-1] == y[WIDTH-1]) && (w_sum[WIDTH-1] != x[WIDTH-1]);
  assign w_ovf_sub = (x[WIDTH-1] != y[WIDTH-1]) && (w_diff[WIDTH-1] != x[WIDTH-1]);

  always_comb begin
    w_f    = '0;
    w_ovf  = 1'b0;
    w_cout = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_f    = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        w_ovf  = w_ovf_add;
      end
      OP_OR:   w_f = x | y;
      OP_AND:  w_f = x & y;
      OP_SUB: begin
        w_f    = w_diff[WIDTH-1:0];
        w_cout = w_diff[WIDTH];
        w_ovf  = w_ovf_sub;
      end
      OP_SLT:  w_f = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1] ^ w_ovf_sub};
      OP_SLTU: w_f = {{(WIDTH-1){1'b0}}, ~w_diff[WIDTH]};
      default: w_f = '0;
    endcase
  end

  // Multiplier: one multiplier bit per MUL cycle; the last step feeds the
  // output register directly, so the product lands WIDTH edges after accept.
  assign w_step     = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_prod     = (r_cnt == CW'(WIDTH)) ? r_acc : w_step;
  assign w_mul_last = (r_state == MUL) && (r_cnt >= CW'(WIDTH - 1));
  assign w_mul_load = w_mul_last && w_out_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_is_mul) w_state_nxt = MUL;
      MUL:     if (w_mul_load) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = !rst && (r_state == IDLE) && w_out_free;
    busy     = (r_state == MUL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_mcand  <= {{WIDTH{1'b0}}, x};
      r_mplier <= y;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if ((r_state == MUL) && (r_cnt != CW'(WIDTH))) begin
      // Completed product parks in r_acc if the output register is still full
      r_acc    <= w_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_f         <= '0;
      r_ovf       <= 1'b0;
      r_cout      <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid <= 1'b1;
      r_f         <= w_f;
      r_ovf       <= w_ovf;
      r_cout      <= w_cout;
      r_zero      <= (w_f == '0);
    end else if (w_mul_load) begin
      r_out_valid <= 1'b1;
      r_f         <= w_prod[WIDTH-1:0];
      r_ovf       <= (w_prod[2*WIDTH-1:WIDTH] != '0);
      r_cout      <= 1'b0;
      r_zero      <= (w_prod[WIDTH-1:0] == '0);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign f         = r_f;
  assign overflow  = r_ovf;
  assign cout      = r_cout;
  assign zero      = r_zero;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases, then randomized
// traffic scored against an arithmetic reference model.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic [2:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f;
  logic        overflow;
  logic        cout;
  logic        zero;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] f;
    logic        ov;
    logic        co;
    logic        z;
  } exp_t;

  exp_t q[$];

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  alu_pipe #(.WIDTH(32), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .overflow(overflow), .cout(cout), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa;
    longint sb;
    longint r;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    e.f = 32'h0; e.ov = 1'b0; e.co = 1'b0;
    case (op)
      3'd0: begin
        p = ua + ub; e.f = p[31:0]; e.co = p[32];
        r = sa + sb; e.ov = (r > SMAX) || (r < SMIN);
      end
      3'd1: e.f = a | b;
      3'd2: e.f = a & b;
      3'd3: begin
        e.f = a - b; e.co = (ua >= ub);
        r = sa - sb; e.ov = (r > SMAX) || (r < SMIN);
      end
      3'd4: e.f = (sa < sb) ? 32'd1 : 32'd0;
      3'd5: e.f = (ua < ub) ? 32'd1 : 32'd0;
      3'd6: begin
        p = ua * ub; e.f = p[31:0]; e.ov = (p[63:32] != 32'h0);
      end
      default: e.f = 32'h0;
    endcase
    e.z = (e.f == 32'h0);
    return e;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Call at a negedge with in_ready high; returns at the negedge after accept.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    opcode = op; x = a; y = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Scoreboard step, sampled after the negedge: head must be on display until consumed.
  task automatic observe();
    exp_t e;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 64'(1), 64'(0));
      end else begin
        e = q[0];
        chk("rnd_f", 64'(f), 64'(e.f));
        chk("rnd_flags", 64'({overflow, cout, zero}), 64'({e.ov, e.co, e.z}));
        if (out_ready) void'(q.pop_front());
      end
    end
  endtask

  initial begin
    int k;
    int bad;
    int seen;
    int busy_bad;
    bit pend;
    logic [2:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; opcode = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_f", 64'(f), 64'(0));
    chk("rst_flags", 64'({overflow, cout, zero}), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(in_ready), 64'(1));

    send(3'd0, 32'd1024, 32'd128);
    chk("add_valid", 64'(out_valid), 64'(1));
    chk("add_f", 64'(f), 64'(1152));
    chk("add_flags", 64'({overflow, cout, zero}), 64'(0));

    send(3'd0, 32'hFFFF_FFFF, 32'd1);
    chk("add_wrap_f", 64'(f), 64'(0));
    chk("add_wrap_flags", 64'({overflow, cout, zero}), 64'(3'b011));

    send(3'd3, 32'h8000_0000, 32'd1);
    chk("sub_ovf_f", 64'(f), 64'(32'h7FFF_FFFF));
    chk("sub_ovf_flags", 64'({overflow, cout, zero}), 64'(3'b110));

    send(3'd4, 32'hFFFF_FFFF, 32'd1);
    chk("slt_f", 64'(f), 64'(1));
    chk("slt_ready_b2b", 64'(in_ready), 64'(1));
    send(3'd5, 32'hFFFF_FFFF, 32'd1);
    chk("sltu_f", 64'(f), 64'(0));
    chk("sltu_flags", 64'({overflow, cout, zero}), 64'(3'b001));

    send(3'd7, 32'd5, 32'd5);
    chk("rsv_f", 64'(f), 64'(0));
    chk("rsv_flags", 64'({overflow, cout, zero}), 64'(3'b001));
    @(negedge clk);

    send(3'd6, 32'd7, 32'd6);
    k = 0; busy_bad = 0;
    while (!out_valid && k < 40) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) busy_bad++;
      @(negedge clk);
      k++;
    end
    chk("mul_latency", 64'(k), 64'(32));
    chk("mul_busy_noready", 64'(busy_bad), 64'(0));
    chk("mul_f", 64'(f), 64'(42));
    chk("mul_flags", 64'({overflow, cout, zero, busy}), 64'(0));
    @(negedge clk);

    send(3'd6, 32'h0001_0000, 32'h0001_0000);
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("mul_big_latency", 64'(k), 64'(32));
    chk("mul_big_f", 64'(f), 64'(0));
    chk("mul_big_flags", 64'({overflow, cout, zero}), 64'(3'b101));
    @(negedge clk);

    out_ready = 1'b0;
    send(3'd0, 32'd10, 32'd20);
    opcode = 3'd1; x = 32'd1; y = 32'd2; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || f !== 32'd30 ||
          {overflow, cout, zero} !== 3'b000) bad++;
      @(negedge clk);
    end
    chk("hold_stable", 64'(bad), 64'(0));
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("consume_accept_valid", 64'(out_valid), 64'(1));
    chk("consume_accept_f", 64'(f), 64'(3));
    @(negedge clk);

    send(3'd6, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mul_abort_valid", 64'(out_valid), 64'(0));
    chk("mul_abort_busy", 64'(busy), 64'(0));
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    chk("mul_abort_no_stale", 64'(seen), 64'(0));

    pend = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        in_valid = 1'b0;
        if ($urandom_range(0, 3) != 0) begin
          rop = 3'($urandom_range(0, 7));
          ra = rnd_operand();
          rb = rnd_operand();
          opcode = rop; x = ra; y = rb; in_valid = 1'b1;
          pend = 1'b1;
        end
      end
      #1;
      observe();
      if (in_valid && in_ready) begin
        q.push_back(model(rop, ra, rb));
        pend = 1'b0;
      end
    end

    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && q.size() > 0; i++) begin
      #1;
      observe();
      @(negedge clk);
    end
    chk("drain_empty", 64'(q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
